// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv pipeline window blocks.
package conv_pkg;

  typedef enum logic [0:0] {
    PAD_ZERO = 1'b0,
    PAD_REPL = 1'b1
  } pad_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } kwin_state_e;

  function automatic int kwin_r(input int k);
    return (k - 1) / 2;
  endfunction

  function automatic int kwin_w(input int k, input int pixel_w);
    return k * k * pixel_w;
  endfunction

endpackage

// File: rtl/conv_kernel_win_shift.sv
// KxK column shift register; next-state window is exported so the caller can register it on the same edge.
// No internal flow control: the caller gates i_shift_en / i_load_sol with its own handshake.
module conv_kernel_win_shift #(
  parameter int K       = 3,
  parameter int PIXEL_W = 8
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   i_shift_en,
  input  logic                   i_load_sol,
  input  logic [K*PIXEL_W-1:0]   i_col,
  input  logic [K*PIXEL_W-1:0]   i_pad,
  output logic [K*PIXEL_W-1:0]   o_newest,
  output logic [K*K*PIXEL_W-1:0] o_win_nxt
);

  localparam int CW = K * PIXEL_W;

  logic [K*CW-1:0] r_win;
  logic [K*CW-1:0] w_win_nxt;

  // Column 0 sits in the LSBs and is the oldest; a shift drops it and appends i_col on top.
  always_comb begin
    w_win_nxt = r_win;
    if (i_load_sol) begin
      for (int i = 0; i < K - 1; i++) begin
        w_win_nxt[i*CW +: CW] = i_pad;
      end
      w_win_nxt[(K-1)*CW +: CW] = i_col;
    end else if (i_shift_en) begin
      w_win_nxt = {i_col, r_win[K*CW-1:CW]};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_win <= '0;
    end else begin
      r_win <= w_win_nxt;
    end
  end

  assign o_newest  = r_win[(K-1)*CW +: CW];
  assign o_win_nxt = w_win_nxt;

endmodule

// File: rtl/conv_kernel_win.sv
// KxK window assembler: one column in, one window per centre column out, one cycle after the column lands.
// Valid/ready on both sides; input stalls while the output slot is full or the line tail is being flushed.
module conv_kernel_win
  import conv_pkg::*;
#(
  parameter int K        = 3,
  parameter int PIXEL_W  = 8,
  parameter int POS_W    = 12,
  parameter int PAD_MODE = 0
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   col_vld_i,
  output logic                   col_rdy_o,
  input  logic                   col_sol_i,
  input  logic                   col_eol_i,
  input  logic [K*PIXEL_W-1:0]   col_dat_i,
  output logic                   kernel_vld_o,
  input  logic                   kernel_rdy_i,
  output logic [K*K*PIXEL_W-1:0] kernel_dat_o,
  output logic [POS_W-1:0]       kernel_col_o,
  output logic                   kernel_eol_o,
  output logic                   drop_o
);

  localparam int R  = kwin_r(K);
  localparam int CW = K * PIXEL_W;
  localparam int WW = kwin_w(K, PIXEL_W);
  localparam logic [POS_W-1:0] C_EMIT = POS_W'(R + 1);
  localparam logic [POS_W-1:0] C_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] C_MAX  = {POS_W{1'b1}};
  localparam bit               REPL   = (PAD_MODE == int'(PAD_REPL));

  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] x);
    return (x == C_MAX) ? x : x + C_ONE;
  endfunction

  kwin_state_e      r_state, w_state_nxt;
  logic [POS_W-1:0] r_acc, r_v, r_out;
  logic [POS_W-1:0] w_acc_nxt, w_v_nxt, w_out_nxt;
  logic             r_kvld, r_keol, r_drop;
  logic [WW-1:0]    r_kdat;
  logic [POS_W-1:0] r_kcol;

  logic             w_slot_free, w_accept;
  logic             w_shift, w_load_sol, w_emit, w_eol, w_drop;
  logic [CW-1:0]    w_new_col, w_pad_col, w_newest;
  logic [WW-1:0]    w_win_nxt;

  assign w_slot_free = ~r_kvld | kernel_rdy_i;
  assign col_rdy_o   = w_slot_free & (r_state != FLUSH);
  assign w_accept    = col_vld_i & col_rdy_o;

  // v counts real plus pad shifts; the centre column lags the newest shift by R.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_v_nxt     = r_v;
    w_out_nxt   = r_out;
    w_shift     = 1'b0;
    w_load_sol  = 1'b0;
    w_emit      = 1'b0;
    w_eol       = 1'b0;
    w_drop      = 1'b0;
    w_new_col   = col_dat_i;
    w_pad_col   = '0;

    case (r_state)
      FLUSH: begin
        if (w_slot_free) begin
          w_shift   = 1'b1;
          w_new_col = REPL ? w_newest : '0;
          w_v_nxt   = sat_inc(r_v);
          w_emit    = (w_v_nxt >= C_EMIT);
        end
      end
      default: begin
        if (w_accept) begin
          if (col_sol_i) begin
            w_load_sol  = 1'b1;
            w_pad_col   = REPL ? col_dat_i : '0;
            w_acc_nxt   = C_ONE;
            w_v_nxt     = C_ONE;
            w_out_nxt   = '0;
            w_drop      = (r_state != IDLE);
            w_state_nxt = col_eol_i ? FLUSH : FILL;
          end else if (r_state == IDLE) begin
            w_drop = 1'b1;
          end else begin
            w_shift   = 1'b1;
            w_acc_nxt = sat_inc(r_acc);
            w_v_nxt   = sat_inc(r_v);
            w_emit    = (w_v_nxt >= C_EMIT);
            if (w_emit) w_state_nxt = RUN;
            if (col_eol_i) w_state_nxt = FLUSH;
          end
        end
      end
    endcase

    if (w_emit) begin
      w_out_nxt = sat_inc(r_out);
      if ((r_state == FLUSH) && (w_out_nxt == r_acc)) begin
        w_eol       = 1'b1;
        w_state_nxt = IDLE;
      end
    end
  end

  conv_kernel_win_shift #(
    .K       (K),
    .PIXEL_W (PIXEL_W)
  ) u_shift (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_shift_en (w_shift),
    .i_load_sol (w_load_sol),
    .i_col      (w_new_col),
    .i_pad      (w_pad_col),
    .o_newest   (w_newest),
    .o_win_nxt  (w_win_nxt)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_v     <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_v     <= w_v_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // An emit only happens with the slot free, so a held window is never overwritten.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_kvld <= 1'b0;
      r_kdat <= '0;
      r_kcol <= '0;
      r_keol <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_emit) begin
        r_kvld <= 1'b1;
        r_kdat <= w_win_nxt;
        r_kcol <= w_v_nxt - C_EMIT;
        r_keol <= w_eol;
      end else if (kernel_rdy_i) begin
        r_kvld <= 1'b0;
      end
    end
  end

  assign kernel_vld_o = r_kvld;
  assign kernel_dat_o = r_kdat;
  assign kernel_col_o = r_kcol;
  assign kernel_eol_o = r_keol;
  assign drop_o       = r_drop;

endmodule

// File: tb/tb_conv_kernel_win.sv
// Scoreboard bench: K=3 zero pad, K=3 replicate and K=5 zero pad instances checked against a clamp/pad line model.
module tb_conv_kernel_win;

  typedef struct {
    logic [199:0] dat;
    int           col;
    bit           eol;
  } exp_t;

  logic clk, arst_n, kernel_rdy;
  logic va, sa, ea, vb, sb, eb;
  logic [23:0] da;
  logic [39:0] db;
  logic ra0, ra1, rb;
  logic kv0, kv1, kv2, ke0, ke1, ke2, dr0, dr1, dr2;
  logic [71:0]  kd0, kd1;
  logic [199:0] kd2;
  logic [11:0]  kc0, kc1, kc2;

  int n_checks = 0;
  int n_fails  = 0;
  bit rdy_rand = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [39:0] line_a [0:127];
  logic [39:0] line_b [0:127];
  int n_a = 0, n_b = 0;
  bit inl_a = 0, inl_b = 0;
  int exp_drop [2];
  int obs_drop [3];

  conv_kernel_win #(.K(3), .PIXEL_W(8), .POS_W(12), .PAD_MODE(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .col_vld_i(va), .col_rdy_o(ra0), .col_sol_i(sa), .col_eol_i(ea),
    .col_dat_i(da), .kernel_vld_o(kv0), .kernel_rdy_i(kernel_rdy), .kernel_dat_o(kd0),
    .kernel_col_o(kc0), .kernel_eol_o(ke0), .drop_o(dr0));

  conv_kernel_win #(.K(3), .PIXEL_W(8), .POS_W(12), .PAD_MODE(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .col_vld_i(va), .col_rdy_o(ra1), .col_sol_i(sa), .col_eol_i(ea),
    .col_dat_i(da), .kernel_vld_o(kv1), .kernel_rdy_i(kernel_rdy), .kernel_dat_o(kd1),
    .kernel_col_o(kc1), .kernel_eol_o(ke1), .drop_o(dr1));

  conv_kernel_win #(.K(5), .PIXEL_W(8), .POS_W(12), .PAD_MODE(0)) dut2 (
    .clk(clk), .arst_n(arst_n), .col_vld_i(vb), .col_rdy_o(rb), .col_sol_i(sb), .col_eol_i(eb),
    .col_dat_i(db), .kernel_vld_o(kv2), .kernel_rdy_i(kernel_rdy), .kernel_dat_o(kd2),
    .kernel_col_o(kc2), .kernel_eol_o(ke2), .drop_o(dr2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    kernel_rdy = 1'b1;
    forever begin
      @(negedge clk);
      kernel_rdy = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end
  end

  function automatic logic [39:0] rcol(input int g);
    logic [31:0] lo, hi;
    logic [39:0] x;
    lo = $urandom;
    hi = $urandom;
    x  = {hi[7:0], lo};
    if (g == 0) x[39:24] = '0;
    return x;
  endfunction

  function automatic logic [39:0] ln(input int g, input int i);
    return (g == 0) ? line_a[i] : line_b[i];
  endfunction

  // Window centred on column c: positions outside the line are zero or the nearest edge column.
  function automatic logic [199:0] win_of(input int g, input int c, input bit repl);
    int k, r, n, idx;
    logic [199:0] w;
    logic [39:0]  cv;
    k = (g == 0) ? 3 : 5;
    r = (k - 1) / 2;
    n = (g == 0) ? n_a : n_b;
    w = '0;
    for (int j = 0; j < k; j++) begin
      idx = c - r + j;
      if (idx < 0)       cv = repl ? ln(g, 0) : '0;
      else if (idx >= n) cv = repl ? ln(g, n - 1) : '0;
      else               cv = ln(g, idx);
      for (int b = 0; b < k * 8; b++) w[j*k*8 + b] = cv[b];
    end
    return w;
  endfunction

  task automatic push_exp(input int g, input int c, input bit e);
    exp_t x;
    x.col = c;
    x.eol = e;
    if (g == 0) begin
      x.dat = win_of(0, c, 1'b0); q0.push_back(x);
      x.dat = win_of(0, c, 1'b1); q1.push_back(x);
    end else begin
      x.dat = win_of(1, c, 1'b0); q2.push_back(x);
    end
  endtask

  task automatic model_accept(input int g, input logic [39:0] dat, input bit sol, input bit eol);
    int k, r, i, c0;
    bit inl;
    k   = (g == 0) ? 3 : 5;
    r   = (k - 1) / 2;
    inl = (g == 0) ? inl_a : inl_b;
    if (!inl && !sol) begin
      exp_drop[g]++;
      return;
    end
    if (sol) begin
      if (inl) exp_drop[g]++;
      if (g == 0) n_a = 0; else n_b = 0;
    end
    if (g == 0) begin
      line_a[n_a] = dat; n_a++; i = n_a - 1; inl_a = 1'b1;
    end else begin
      line_b[n_b] = dat; n_b++; i = n_b - 1; inl_b = 1'b1;
    end
    if (i >= r) push_exp(g, i - r, 1'b0);
    if (eol) begin
      c0 = (i - r + 1 > 0) ? i - r + 1 : 0;
      for (int c = c0; c <= i; c++) push_exp(g, c, c == i);
      if (g == 0) inl_a = 1'b0; else inl_b = 1'b0;
    end
  endtask

  // Entered on a negedge; returns on the negedge after the accepting posedge with valid dropped.
  task automatic send(input int g, input logic [39:0] dat, input bit sol, input bit eol);
    bit ok;
    ok = 1'b0;
    if (g == 0) begin va = 1'b1; sa = sol; ea = eol; da = dat[23:0]; end
    else        begin vb = 1'b1; sb = sol; eb = eol; db = dat;       end
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      #1;
      if ((g == 0) ? ra0 : rb) begin
        ok = 1'b1;
        model_accept(g, dat, sol, eol);
      end
      @(negedge clk);
    end
    va = 1'b0;
    vb = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL send_timeout grp%0d: column accepted=%0b, required 1 within 200 cycles", g, ok);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input int d, output logic v, output logic [199:0] dat, output logic [11:0] col,
                        output logic eol, output logic crdy, output logic drp);
    case (d)
      0:       begin v = kv0; dat = {128'b0, kd0}; col = kc0; eol = ke0; crdy = ra0; drp = dr0; end
      1:       begin v = kv1; dat = {128'b0, kd1}; col = kc1; eol = ke1; crdy = ra1; drp = dr1; end
      default: begin v = kv2; dat = kd2;           col = kc2; eol = ke2; crdy = rb;  drp = dr2; end
    endcase
  endtask

  task automatic check_zero(input int d, input string tag);
    logic v, e, cr, dp;
    logic [199:0] dat;
    logic [11:0] col;
    sample(d, v, dat, col, e, cr, dp);
    n_checks++;
    if (v !== 1'b0 || dat !== '0 || col !== '0 || e !== 1'b0 || dp !== 1'b0) begin
      n_fails++;
      $display("FAIL %s dut%0d: vld=%0b col=%0d eol=%0b drop=%0b dat=%h, required all 0", tag, d, v, col, e, dp, dat);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; stalls must hold data and block the input side.
  bit           pstall [3];
  logic [199:0] pdat   [3];
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 3; d++) begin
        logic v, e, cr, dp;
        logic [199:0] dat;
        logic [11:0] col;
        exp_t x;
        bit have;
        sample(d, v, dat, col, e, cr, dp);
        if (dp) obs_drop[d]++;
        if (pstall[d]) begin
          n_checks++;
          if (v !== 1'b1 || dat !== pdat[d]) begin
            n_fails++;
            $display("FAIL stall_hold dut%0d: vld=%0b dat=%h, required vld=1 dat=%h", d, v, dat, pdat[d]);
          end
        end
        if (v && !kernel_rdy) begin
          n_checks++;
          if (cr !== 1'b0) begin
            n_fails++;
            $display("FAIL rdy_while_full dut%0d: col_rdy=%0b, required 0", d, cr);
          end
        end
        if (v && kernel_rdy) begin
          have = 1'b0;
          case (d)
            0:       if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
          endcase
          n_checks++;
          if (!have) begin
            n_fails++;
            $display("FAIL extra_window dut%0d: got col=%0d dat=%h, required no window", d, col, dat);
          end else if (dat !== x.dat || col !== 12'(x.col) || e !== x.eol) begin
            n_fails++;
            $display("FAIL window dut%0d: got col=%0d eol=%0b dat=%h, required col=%0d eol=%0b dat=%h",
                     d, col, e, dat, x.col, x.eol, x.dat);
          end
        end
        pstall[d] = v && !kernel_rdy;
        pdat[d]   = dat;
      end
    end
  end

  initial begin
    int lowcnt;
    va = 0; sa = 0; ea = 0; da = '0;
    vb = 0; sb = 0; eb = 0; db = '0;
    exp_drop[0] = 0; exp_drop[1] = 0;
    obs_drop[0] = 0; obs_drop[1] = 0; obs_drop[2] = 0;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) check_zero(d, "reset_state");
    idle(2);
    arst_n = 1'b1;
    idle(1);

    // 4-column line at full rate, then the single FLUSH cycle of input backpressure
    send(0, rcol(0), 1, 0);
    send(0, rcol(0), 0, 0);
    send(0, rcol(0), 0, 0);
    send(0, rcol(0), 0, 1);
    lowcnt = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      #1;
      if (ra0) break;
      lowcnt++;
      @(negedge clk);
    end
    n_checks++;
    if (lowcnt != 1) begin
      n_fails++;
      $display("FAIL flush_rdy_low: col_rdy low for %0d cycles, required 1", lowcnt);
    end
    @(negedge clk);

    send(0, rcol(0), 1, 1);
    send(0, rcol(0), 0, 0);

    // line abandoned by a fresh sol, then a short replacement line
    send(0, rcol(0), 1, 0);
    for (int i = 0; i < 3; i++) send(0, rcol(0), 0, 0);
    send(0, rcol(0), 1, 0);
    send(0, rcol(0), 0, 0);
    send(0, rcol(0), 0, 1);

    rdy_rand = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(0, rcol(0), i == 0, i == 63);
      if ($urandom_range(3, 0) == 0) idle(1);
    end

    rdy_rand = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) send(0, rcol(0), i == 0, i == 3);
    arst_n = 1'b0;
    q0.delete();
    q1.delete();
    inl_a = 1'b0;
    n_a   = 0;
    #3;
    check_zero(0, "reset_mid_flush");
    check_zero(1, "reset_mid_flush");
    @(negedge clk);
    arst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) send(0, rcol(0), i == 0, i == 4);

    send(1, rcol(1), 1, 0);
    send(1, rcol(1), 0, 1);
    send(1, rcol(1), 1, 1);
    rdy_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(1, rcol(1), i == 0, i == 11);
      if ($urandom_range(2, 0) == 0) idle(1);
    end

    rdy_rand = 1'b0;
    for (int cyc = 0; cyc < 300 && (q0.size() + q1.size() + q2.size()) > 0; cyc++) @(negedge clk);
    idle(4);

    n_checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      n_fails++;
      $display("FAIL drain: pending windows %0d/%0d/%0d, required 0/0/0", q0.size(), q1.size(), q2.size());
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (obs_drop[d] != exp_drop[(d == 2) ? 1 : 0]) begin
        n_fails++;
        $display("FAIL drop_count dut%0d: got %0d, required %0d", d, obs_drop[d], exp_drop[(d == 2) ? 1 : 0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
